// File: rtl/id_hazard_redirect_if.sv
// IF <-> ID control loop: IF presents a fetched instruction and PC every cycle;
// ID answers with redirect requests (Branch/Jump/JumpAddr) and the IFWrite enable.
interface id_hazard_redirect_if;
    // Handshake: IF holds Instruction_if/PC stable while IFWrite=0 (ready low);
    // IF_flush squashes the presented word regardless of IFWrite.
    logic [31:0] Instruction_if;
    logic [31:0] PC;
    logic        IF_flush;
    logic        Branch;
    logic        Jump;
    logic [31:0] JumpAddr;
    logic        IFWrite;

    modport master (
        output Instruction_if, PC, IF_flush,
        input  Branch, Jump, JumpAddr, IFWrite
    );

    modport slave (
        input  Instruction_if, PC, IF_flush,
        output Branch, Jump, JumpAddr, IFWrite
    );
endinterface

// File: rtl/id_hazard_redirect.sv
// IF/ID pipeline register, ID decode, hazard bubbles and redirect back into IF.
// Optional build macro ID_PERF_CNT_EN adds saturating stall/flush counters.
module id_hazard_redirect #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    id_hazard_redirect_if.slave if_bus,
    input  logic [31:0] RsData_id,
    input  logic [31:0] RtData_id,
    input  logic        MemRead_ex,
    input  logic        RegWrite_ex,
    input  logic [4:0]  WriteReg_ex,
    input  logic        MemRead_mem,
    input  logic [4:0]  WriteReg_mem,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id,
    output logic        valid_id,
    output logic        stall_id
`ifdef ID_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [31:0] r_instr_id;
    logic [31:0] r_pc_id;
    logic        r_valid_id;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_is_jump;
    logic        w_is_br;
    logic        w_uses_rt;
    logic        w_ex_hit_rs;
    logic        w_ex_hit_rt;
    logic        w_mem_hit_rs;
    logic        w_mem_hit_rt;
    logic        w_load_use;
    logic        w_br_haz;
    logic        w_stall;
    logic        w_br_taken;
    logic [3:0]  w_ja_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_id <= NOP_INSTR;
            r_pc_id    <= PC_RESET;
            r_valid_id <= 1'b0;
        end else if (if_bus.IF_flush) begin
            r_instr_id <= NOP_INSTR;
            r_pc_id    <= if_bus.PC;
            r_valid_id <= 1'b0;
        end else if (!w_stall) begin
            r_instr_id <= if_bus.Instruction_if;
            r_pc_id    <= if_bus.PC;
            r_valid_id <= 1'b1;
        end
    end

    assign w_op      = r_instr_id[31:26];
    assign w_rs      = r_instr_id[25:21];
    assign w_rt      = r_instr_id[20:16];
    assign w_is_jump = (w_op == OP_J) || (w_op == OP_JAL);
    assign w_is_br   = (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_uses_rt = (w_op == OP_RTYPE) || w_is_br || (w_op == OP_SW);

    // $0 is hard-wired, so a producer targeting it never blocks a consumer.
    assign w_ex_hit_rs  = (WriteReg_ex  != 5'd0) && (WriteReg_ex  == w_rs);
    assign w_ex_hit_rt  = (WriteReg_ex  != 5'd0) && (WriteReg_ex  == w_rt);
    assign w_mem_hit_rs = (WriteReg_mem != 5'd0) && (WriteReg_mem == w_rs);
    assign w_mem_hit_rt = (WriteReg_mem != 5'd0) && (WriteReg_mem == w_rt);

    assign w_load_use = MemRead_ex && (w_ex_hit_rs || (w_uses_rt && w_ex_hit_rt));
    assign w_br_haz   = w_is_br &&
                        ((RegWrite_ex && (w_ex_hit_rs || w_ex_hit_rt)) ||
                         (MemRead_mem && (w_mem_hit_rs || w_mem_hit_rt)));
    assign w_stall    = r_valid_id && (w_load_use || w_br_haz);

    assign w_br_taken = (w_op == OP_BEQ) ? (RsData_id == RtData_id)
                                         : (RsData_id != RtData_id);

    // Top nibble of PC_id+4: carry into bit 28 only when bits [27:2] are all ones.
    assign w_ja_hi = r_pc_id[31:28] + {3'b000, &r_pc_id[27:2]};

    assign if_bus.IFWrite  = ~w_stall;
    assign if_bus.Jump     = r_valid_id && w_is_jump && !w_stall;
    assign if_bus.Branch   = r_valid_id && !w_stall && w_is_br && w_br_taken;
    assign if_bus.JumpAddr = {w_ja_hi, r_instr_id[25:0], 2'b00};

    assign Instruction_id = r_instr_id;
    assign PC_id          = r_pc_id;
    assign valid_id       = r_valid_id;
    assign stall_id       = w_stall;

`ifdef ID_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (if_bus.IF_flush && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_hazard_redirect.sv
// Directed bench for id_hazard_redirect: driver pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_id_hazard_redirect;

    localparam int W = 101;

    logic        clk;
    logic        reset;
    logic [31:0] RsData_id, RtData_id;
    logic        MemRead_ex, RegWrite_ex, MemRead_mem;
    logic [4:0]  WriteReg_ex, WriteReg_mem;
    logic [31:0] Instruction_id, PC_id;
    logic        valid_id, stall_id;
`ifdef ID_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    id_hazard_redirect_if bus ();

    id_hazard_redirect dut (
        .clk            (clk),
        .reset          (reset),
        .if_bus         (bus),
        .RsData_id      (RsData_id),
        .RtData_id      (RtData_id),
        .MemRead_ex     (MemRead_ex),
        .RegWrite_ex    (RegWrite_ex),
        .WriteReg_ex    (WriteReg_ex),
        .MemRead_mem    (MemRead_mem),
        .WriteReg_mem   (WriteReg_mem),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id),
        .valid_id       (valid_id),
        .stall_id       (stall_id)
`ifdef ID_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    string        name_q[$];
    int           n_total = 0;
    int           n_bad   = 0;
    logic         done    = 1'b0;

    // driver tasks
    task automatic cyc(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic mr_ex, input logic rw_ex, input logic [4:0] wr_ex,
                       input logic mr_mem, input logic [4:0] wr_mem);
        @(posedge clk);
        #1;
        bus.Instruction_if = ins;
        bus.PC             = pc;
        bus.IF_flush       = fl;
        RsData_id          = rsd;
        RtData_id          = rtd;
        MemRead_ex         = mr_ex;
        RegWrite_ex        = rw_ex;
        WriteReg_ex        = wr_ex;
        MemRead_mem        = mr_mem;
        WriteReg_mem       = wr_mem;
    endtask

    task automatic push_exp(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                            input logic v, input logic br, input logic j,
                            input logic ja_en, input logic [31:0] ja,
                            input logic ifw, input logic st);
        logic [W-1:0] m;
        m = '1;
        if (!ja_en) m[33:2] = '0;
        exp_q.push_back({ins, pc, v, br, j, ja, ifw, st});
        msk_q.push_back(m);
        name_q.push_back(nm);
    endtask

    task automatic chk(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                       input logic v, input logic br, input logic j,
                       input logic ifw, input logic st);
        push_exp(nm, ins, pc, v, br, j, 1'b0, 32'h0, ifw, st);
    endtask

    task automatic chk_ja(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                          input logic v, input logic br, input logic j,
                          input logic [31:0] ja, input logic ifw, input logic st);
        push_exp(nm, ins, pc, v, br, j, 1'b1, ja, ifw, st);
    endtask

    task automatic cmp16(input string nm, input logic [15:0] act, input logic [15:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, want);
        end
    endtask

    // monitor
    initial begin
        logic [W-1:0] act, e, m;
        string nm;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                m  = msk_q.pop_front();
                nm = name_q.pop_front();
                act = {Instruction_id, PC_id, valid_id, bus.Branch, bus.Jump,
                       bus.JumpAddr, bus.IFWrite, stall_id};
                n_total++;
                if (((act ^ e) & m) !== '0) begin
                    n_bad++;
                    $display("FAIL %s: ins=%h pc=%h v=%b br=%b j=%b ja=%h ifw=%b st=%b | want ins=%h pc=%h v=%b br=%b j=%b ja=%h ifw=%b st=%b",
                             nm, act[100:69], act[68:37], act[36], act[35], act[34], act[33:2], act[1], act[0],
                             e[100:69], e[68:37], e[36], e[35], e[34], e[33:2], e[1], e[0]);
                end
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        if (!done) begin
            n_bad++;
            $display("FAIL watchdog: got=timeout want=finish");
            $display("test done: total=%0d bad=%0d", n_total, n_bad);
            $finish;
        end
    end

    localparam logic [31:0] I_A   = 32'h2001_0005; // addi $1,$0,5
    localparam logic [31:0] I_B   = 32'h2002_0003; // addi $2,$0,3
    localparam logic [31:0] I_ADD = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] I_LW  = 32'h8C01_0000; // lw $1,0($0)
    localparam logic [31:0] I_BEQ = 32'h1085_0003; // beq $4,$5,+3
    localparam logic [31:0] I_J   = 32'h0800_0005; // j 0x0000005
    localparam logic [31:0] I_BNE = 32'h1420_0002; // bne $1,$0,+2
    localparam logic [31:0] I_R0  = 32'h0000_2020; // add $4,$0,$0
    localparam logic [31:0] I_BQ2 = 32'h1043_0001; // beq $2,$3,+1

    initial begin
        reset = 1'b0;
        bus.Instruction_if = 32'h0; bus.PC = 32'h0; bus.IF_flush = 1'b1;
        RsData_id = 0; RtData_id = 0;
        MemRead_ex = 0; RegWrite_ex = 0; WriteReg_ex = 0;
        MemRead_mem = 0; WriteReg_mem = 0;

        #52;
        chk_ja("reset_state", 32'h0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
        #50 reset = 1'b1;

        // straight-line fetch: ID trails IF by one clock
        cyc(I_A,   32'h00, 0, 0, 0, 0, 0, 0, 0, 0); chk("flush_bubble_boot", 32'h0, 32'h0, 0, 0, 0, 1, 0);
        cyc(I_B,   32'h04, 0, 0, 0, 0, 0, 0, 0, 0); chk("pipe_pc0", I_A, 32'h00, 1, 0, 0, 1, 0);
        cyc(I_ADD, 32'h08, 0, 0, 0, 0, 0, 0, 0, 0); chk("pipe_pc4", I_B, 32'h04, 1, 0, 0, 1, 0);
        cyc(I_LW,  32'h0C, 0, 0, 0, 0, 0, 0, 0, 0); chk("pipe_pc8", I_ADD, 32'h08, 1, 0, 0, 1, 0);
        cyc(I_ADD, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0); chk("pipe_pc12", I_LW, 32'h0C, 1, 0, 0, 1, 0);

        // load-use: one bubble, ID held
        cyc(I_A,   32'h14, 0, 0, 0, 1, 1, 5'd1, 0, 0); chk("loaduse_stall", I_ADD, 32'h10, 1, 0, 0, 0, 1);
        cyc(I_A,   32'h14, 0, 0, 0, 0, 0, 0, 1, 5'd1); chk("loaduse_release", I_ADD, 32'h10, 1, 0, 0, 1, 0);
        cyc(I_BEQ, 32'h18, 0, 0, 0, 0, 0, 0, 0, 0); chk("pipe_pc20", I_A, 32'h14, 1, 0, 0, 1, 0);

        // beq taken, IF flushes the fall-through fetch
        cyc(32'h2006_0001, 32'h1C, 1, 7, 7, 0, 0, 0, 0, 0); chk("beq_taken", I_BEQ, 32'h18, 1, 1, 0, 1, 0);
        cyc(I_BEQ, 32'h28, 0, 0, 0, 0, 0, 0, 0, 0); chk("beq_flush_nop", 32'h0, 32'h1C, 0, 0, 0, 1, 0);
        cyc(I_J,   32'h24, 0, 7, 8, 0, 0, 0, 0, 0); chk("beq_not_taken", I_BEQ, 32'h28, 1, 0, 0, 1, 0);

        // jumps: low and high regions, and PC_id+4 wrapping
        cyc(I_J, 32'h28, 1, 0, 0, 0, 0, 0, 0, 0); chk_ja("jump_low", I_J, 32'h24, 1, 0, 1, 32'h0000_0014, 1, 0);
        cyc(I_J, 32'hF000_0000, 0, 0, 0, 0, 0, 0, 0, 0); chk_ja("jump_flush_nop", 32'h0, 32'h28, 0, 0, 0, 32'h0, 1, 0);
        cyc(I_J, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0); chk_ja("jump_hi_nibble", I_J, 32'hF000_0000, 1, 0, 1, 32'hF000_0014, 1, 0);
        cyc(I_BNE, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0); chk_ja("jump_pc_wrap", I_J, 32'hFFFF_FFFC, 1, 0, 1, 32'h0000_0014, 1, 0);

        // load feeding bne: stall in EX then MEM, then branch resolves
        cyc(32'h2007_0009, 32'h34, 0, 5, 0, 1, 1, 5'd1, 0, 0); chk("ldbr_stall_ex", I_BNE, 32'h30, 1, 0, 0, 0, 1);
        cyc(32'h2007_0009, 32'h34, 0, 5, 0, 0, 0, 0, 1, 5'd1); chk("ldbr_stall_mem", I_BNE, 32'h30, 1, 0, 0, 0, 1);
        cyc(32'h2007_0009, 32'h38, 1, 5, 0, 0, 0, 0, 0, 0); chk("ldbr_bne_taken", I_BNE, 32'h30, 1, 1, 0, 1, 0);
        cyc(I_R0, 32'h3C, 0, 0, 0, 0, 0, 0, 0, 0); chk("bne_flush_nop", 32'h0, 32'h38, 0, 0, 0, 1, 0);

        // $0 never hazards; ALU producer vs branch; flush beats stall
        cyc(I_BQ2, 32'h40, 0, 0, 0, 1, 1, 5'd0, 1, 5'd0); chk("reg0_no_haz", I_R0, 32'h3C, 1, 0, 0, 1, 0);
        cyc(32'h2008_0001, 32'h44, 0, 1, 1, 0, 1, 5'd3, 0, 0); chk("br_alu_haz", I_BQ2, 32'h40, 1, 0, 0, 0, 1);
        cyc(32'h2008_0001, 32'h44, 0, 1, 1, 0, 0, 0, 1, 5'd2); chk("br_mem_haz", I_BQ2, 32'h40, 1, 0, 0, 0, 1);
        cyc(32'h2008_0001, 32'h48, 1, 1, 1, 0, 0, 0, 1, 5'd2); chk("stall_with_flush", I_BQ2, 32'h40, 1, 0, 0, 0, 1);
        cyc(I_BNE, 32'h50, 0, 0, 0, 0, 0, 0, 1, 5'd2); chk("flush_over_stall", 32'h0, 32'h48, 0, 0, 0, 1, 0);

        // async reset in the middle of a stall
        cyc(I_A, 32'h54, 0, 5, 0, 1, 1, 5'd1, 0, 0); chk("pre_reset_stall", I_BNE, 32'h50, 1, 0, 0, 0, 1);
        @(negedge clk);
        #2;
        chk_ja("async_reset", 32'h0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        bus.Instruction_if = I_A; bus.PC = 32'h0; bus.IF_flush = 1'b0;
        MemRead_ex = 0; RegWrite_ex = 0; WriteReg_ex = 0; MemRead_mem = 0; WriteReg_mem = 0;
        #2 reset = 1'b1;

        cyc(I_ADD, 32'h04, 0, 0, 0, 0, 0, 0, 0, 0); chk("post_reset_fetch", I_A, 32'h00, 1, 0, 0, 1, 0);
        cyc(I_B, 32'h08, 0, 0, 0, 1, 1, 5'd1, 0, 0); chk("perf_stall1", I_ADD, 32'h04, 1, 0, 0, 0, 1);
        cyc(I_B, 32'h08, 0, 0, 0, 1, 1, 5'd1, 0, 0); chk("perf_stall2", I_ADD, 32'h04, 1, 0, 0, 0, 1);
        cyc(I_B, 32'h08, 0, 0, 0, 1, 1, 5'd1, 0, 0); chk("perf_stall3", I_ADD, 32'h04, 1, 0, 0, 0, 1);
        cyc(I_B, 32'h0C, 1, 0, 0, 0, 0, 0, 0, 0); chk("perf_clear", I_ADD, 32'h04, 1, 0, 0, 1, 0);
        cyc(I_B, 32'h10, 1, 0, 0, 0, 0, 0, 0, 0); chk("perf_flush1", 32'h0, 32'h0C, 0, 0, 0, 1, 0);
        cyc(I_ADD, 32'h14, 0, 0, 0, 0, 0, 0, 0, 0); chk("perf_flush2", 32'h0, 32'h10, 0, 0, 0, 1, 0);
`ifdef ID_PERF_CNT_EN
        cmp16("stall_cnt_3", stall_cnt, 16'd3);
        cmp16("flush_cnt_2", flush_cnt, 16'd2);
        cyc(I_B, 32'h18, 0, 0, 0, 1, 1, 5'd1, 0, 0);
        repeat (70000) @(posedge clk);
        #1;
        cmp16("stall_cnt_sat", stall_cnt, 16'hFFFF);
        cmp16("flush_cnt_hold", flush_cnt, 16'd2);
`endif

        repeat (2) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL queue_drain: got=%0d want=0", exp_q.size());
        end
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/id_hazard_redirect.md
Name: id_hazard_redirect

Overview:
- Consumer side of the IF stage interface: holds the IF/ID pipeline register, decodes the instruction in ID and closes the control loop back into IF.
- Inputs from IF: Instruction_if, PC, IF_flush.
- Drives IF's control inputs: Branch, Jump, JumpAddr, IFWrite.
- Detects load-use and branch-operand hazards and inserts ID bubbles.

Parameters:
NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on reset or flush
PC_RESET, 32'h0000_0000, PC_id value after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
Instruction_if  in  32  instruction fetched by IF
PC  in  32  address of Instruction_if
IF_flush  in  1  IF requests squash of the fetched instruction
RsData_id  in  32  register-file read of rs (combinational)
RtData_id  in  32  register-file read of rt (combinational)
MemRead_ex  in  1  instruction in EX is a load
RegWrite_ex  in  1  instruction in EX writes a register
WriteReg_ex  in  5  destination register of EX instruction
MemRead_mem  in  1  instruction in MEM is a load
WriteReg_mem  in  5  destination register of MEM instruction
Instruction_id  out  32  IF/ID registered instruction
PC_id  out  32  IF/ID registered PC
valid_id  out  1  IF/ID holds a real (non-bubble) instruction
Branch  out  1  taken BEQ/BNE in ID, to IF
Jump  out  1  J/JAL in ID, to IF
JumpAddr  out  32  jump target, to IF
IFWrite  out  1  PC/IF enable, to IF; 0 = stall
stall_id  out  1  force bubble into ID/EX this cycle

Behaviour:
- Reset (reset=0, async): Instruction_id=NOP_INSTR, PC_id=PC_RESET, valid_id=0. All combinational outputs follow: Branch=Jump=0, IFWrite=1, stall_id=0, JumpAddr={PC_RESET+4 high nibble, 26'b0, 2'b00}.
- IF/ID register update priority, each rising clk:
  - IF_flush=1: load NOP_INSTR, PC, valid_id=0. Flush wins over stall.
  - Else stall=1: hold all three.
  - Else: load Instruction_if, PC, valid_id=1.
- Latency: fetched instruction visible on Instruction_id one clock after IF presents it.
- Decode of Instruction_id (ignored when valid_id=0):
  - op=[31:26], rs=[25:21], rt=[20:16].
  - J=6'b000010, JAL=6'b000011 -> is_jump.
  - BEQ=6'b000100, BNE=6'b000101 -> is_br.
  - uses_rt when op is 0 (R-type), BEQ, BNE or SW (6'b101011).
- Load-use hazard: MemRead_ex & WriteReg_ex!=0 & (WriteReg_ex==rs | (uses_rt & WriteReg_ex==rt)).
- Branch operand hazard: is_br and either
  - RegWrite_ex & WriteReg_ex!=0 & WriteReg_ex in {rs, rt}, or
  - MemRead_mem & WriteReg_mem!=0 & WriteReg_mem in {rs, rt}.
- stall = valid_id & (load-use | branch hazard). Stall lasts until the hazard clears; a load feeding a branch therefore costs 2 cycles.
- IFWrite = ~stall; stall_id = stall.
- Jump = valid_id & is_jump & ~stall.
- Branch = valid_id & ~stall & is_br & (BEQ ? RsData_id==RtData_id : RsData_id!=RtData_id).
- JumpAddr = {PC_id+4 bits[31:28], Instruction_id[25:0], 2'b00}; PC_id+4 wraps modulo 2^32. JumpAddr is driven every cycle, meaningful only while Jump=1.
- Branch/Jump are forced low during stall, so this block never requests a redirect and a stall in the same cycle. If IF asserts IF_flush while IFWrite=0, flush priority above applies.
- Register 0 never causes a hazard.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Count clock edges with stall=1 and with IF_flush=1 respectively.
  - Saturate at 16'hFFFF; cleared by reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset held low 100 ns, then released; IF presents PC=0..12 with 32'h2001_0005 etc. -> Instruction_id/PC_id trail IF by 1 clock; valid_id=1; IFWrite=1 throughout.
- lw $1 in EX (MemRead_ex=1, WriteReg_ex=1); ID holds add $3,$1,$2 -> stall_id=1, IFWrite=0 for exactly 1 cycle; Instruction_id and PC_id held.
- ID holds beq $4,$5,+3 with RsData_id=RtData_id=7 -> Branch=1 for 1 cycle; IF_flush=1 next edge loads NOP with valid_id=0. Repeat with values 7 and 8 -> Branch=0.
- ID holds j 0x0000005 at PC_id=32'h0000_0024 -> Jump=1, JumpAddr=32'h0000_0014. Then PC_id=32'hF000_0000 -> JumpAddr upper nibble = 4'hF.
- ID holds bne $1,$0 with lw $1 in EX -> 2 stall cycles (EX then MEM), then Branch is evaluated. reset pulsed low mid-stall -> outputs return to reset values asynchronously.
- With ID_PERF_CNT_EN defined: 3 stalls and 2 flushes -> stall_cnt=3, flush_cnt=2. Force 70000 stall cycles -> stall_cnt=16'hFFFF.
